// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  localparam int WCW = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between CPU and DMA requests.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise CPU has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_owner
);

  assign grant_valid = cpu_req | dma_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant_owner = OWNER_CPU;
    if (cpu_req && dma_req) grant_owner = ~last_grant;
    else if (dma_req)       grant_owner = OWNER_DMA;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_owner = OWNER_CPU;
    if (!cpu_req && dma_req) grant_owner = OWNER_DMA;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU control path and a DMA/debug loader.
// Optional round-robin tie-break: define MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy,
  output state_t        state
);

  localparam logic [WCW-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? WCW'(WAIT_CYCLES - 1) : '0;

  state_t         state_nx;
  logic [WCW-1:0] wcnt;
  logic           we_q;
  logic           owner_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  wdata_q;
  logic [DW-1:0]  cpu_rdata_q;
  logic [DW-1:0]  dma_rdata_q;
  logic           last_grant;
  logic           grant_valid;
  logic           grant_owner;
  logic           grant;
  logic           enter_done;

  mem_arb_pick u_pick (
    .cpu_req     (cpu_req),
    .dma_req     (dma_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  assign grant      = (state == ST_IDLE) && grant_valid;
  assign enter_done = (state_nx == ST_DONE) && (state != ST_DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (grant_valid) state_nx = ST_ACCESS;
      ST_ACCESS: state_nx = (WAIT_CYCLES > 0) ? ST_WAIT : ST_DONE;
      ST_WAIT:   if (wcnt == '0) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Requester inputs are captured at grant so later changes cannot disturb the access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q <= OWNER_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      owner_q <= grant_owner;
      we_q    <= (grant_owner == OWNER_DMA) ? dma_we    : cpu_we;
      addr_q  <= (grant_owner == OWNER_DMA) ? dma_addr  : cpu_addr;
      wdata_q <= (grant_owner == OWNER_DMA) ? dma_wdata : cpu_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                               wcnt <= '0;
    else if (state == ST_ACCESS)             wcnt <= WAIT_LOAD;
    else if (state == ST_WAIT && wcnt != '0) wcnt <= wcnt - 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else if (enter_done && !we_q) begin
      if (owner_q == OWNER_DMA) dma_rdata_q <= mem_rdata;
      else                      cpu_rdata_q <= mem_rdata;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      last_grant <= OWNER_DMA;
    else if (grant) last_grant <= grant_owner;
  end
`else
  assign last_grant = OWNER_DMA;
`endif

  assign mem_en    = (state == ST_ACCESS);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign owner     = owner_q;
  assign busy      = (state != ST_IDLE);
  assign cpu_ready = (state == ST_DONE) && (owner_q == OWNER_CPU);
  assign dma_ready = (state == ST_DONE) && (owner_q == OWNER_DMA);
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule
